// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Core, debug-master and RAM signal bundle for ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // Core datapath side
  logic              core_req;
  logic              core_wen;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  // Debug / loader master side
  logic              dbg_req;
  logic              dbg_wen;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  // Data RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  core_req, core_wen, core_addr, core_wdata,
    input  dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    input  ram_rdata,
    output core_rdata, core_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_addr, ram_wen, ram_wdata
  );

  modport master (
    output core_req, core_wen, core_addr, core_wdata,
    output dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    output ram_rdata,
    input  core_rdata, core_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_addr, ram_wen, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares the single-port data RAM between the core and a debug
//            master; core has priority, debug is forced in after MAX_WAIT denials.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ram_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              dbg_gnt;
  logic              core_stall;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Grant, stall and RAM mux; everything that can disturb the RAM is held
  // off while reset is asserted.
  always_comb begin
    dbg_gnt    = 1'b0;
    core_stall = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = bus.core_addr;
    ram_wdata  = bus.core_wdata;

    if (rst) begin
      dbg_gnt    = bus.dbg_req & ((state_q == ST_FORCE) | ~bus.core_req);
      core_stall = bus.core_req & dbg_gnt;
      if (dbg_gnt) begin
        ram_addr  = bus.dbg_addr;
        ram_wdata = bus.dbg_wdata;
        ram_wen   = bus.dbg_wen;
      end else begin
        ram_wen   = bus.core_req & bus.core_wen;
      end
    end
  end

  // Starvation counter and next state
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    state_d      = state_q;
    dbg_rvalid_d = dbg_gnt & ~bus.dbg_wen;
    dbg_rdata_d  = dbg_rdata_q;

    if (dbg_gnt || !bus.dbg_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != c_max_wait) begin
      wait_cnt_d = wait_cnt_q + c_cnt_one;
    end

    case (state_q)
      ST_NORMAL: if (wait_cnt_d == c_max_wait) state_d = ST_FORCE;
      ST_FORCE:  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase

    if (dbg_rvalid_d) begin
      dbg_rdata_d = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_NORMAL;
      wait_cnt_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign bus.core_rdata = bus.ram_rdata;
  assign bus.core_stall = core_stall;
  assign bus.dbg_gnt    = dbg_gnt;
  // A read completing as reset goes low is cancelled immediately.
  assign bus.dbg_rvalid = dbg_rvalid_q & rst;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wen    = ram_wen;
  assign bus.ram_wdata  = ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench for ram_port_arbiter with a behavioural RAM
//            and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: combinational read, posedge write
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every debug read result is compared against the queued value
  always @(negedge clk) begin
    if (bus.dbg_rvalid === 1'b1) begin
      if (sb_q.size() == 0) check_eq("rvalid_unexpected", 32'd1, 32'd0);
      else                  check_eq("dbg_rdata", bus.dbg_rdata, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                       input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
    bus.core_req   = cr;
    bus.core_wen   = cw;
    bus.core_addr  = ca;
    bus.core_wdata = cd;
    bus.dbg_req    = dr;
    bus.dbg_wen    = dw;
    bus.dbg_addr   = da;
    bus.dbg_wdata  = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset held with every request active
    rst = 1'b0;
    drive(1'b1, 1'b1, 11'h005, 32'h1111_1111, 1'b1, 1'b1, 11'h006, 32'h2222_2222);
    repeat (3) next_cycle();
    #1;
    check_eq("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
    check_eq("rst_ram_wen",    32'(bus.ram_wen),    32'd0);
    check_eq("rst_core_stall", 32'(bus.core_stall), 32'd0);
    check_eq("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

    // First cycle after release is NORMAL: core wins
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b0, 11'h007, '0, 1'b1, 1'b0, 11'h007, '0);
    check_eq("post_rst_gnt",   32'(bus.dbg_gnt),    32'd0);
    check_eq("post_rst_stall", 32'(bus.core_stall), 32'd0);
    next_cycle();
    idle();

    // Core write then read back through the combinational path
    next_cycle();
    drive(1'b1, 1'b1, 11'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
    check_eq("core_wr_wen",   32'(bus.ram_wen),    32'd1);
    check_eq("core_wr_stall", 32'(bus.core_stall), 32'd0);
    check_eq("core_wr_addr",  32'(bus.ram_addr),   32'h005);
    next_cycle();
    drive(1'b1, 1'b0, 11'h005, '0, 1'b0, 1'b0, '0, '0);
    check_eq("core_rd_data", bus.core_rdata, 32'hDEAD_BEEF);
    check_eq("core_rd_wen",  32'(bus.ram_wen), 32'd0);

    // Debug-only read: grant in N, rvalid in N+1
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h005, '0);
    sb_q.push_back(32'hDEAD_BEEF);
    check_eq("dbg_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
    next_cycle();
    idle();
    check_eq("dbg_rd_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    next_cycle();
    check_eq("dbg_rd_rvalid_drop", 32'(bus.dbg_rvalid), 32'd0);

    // Starvation: forced debug grant every MAX_WAIT+1 cycles
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 11'h020, '0, 1'b1, 1'b0, 11'h005, '0);
      check_eq($sformatf("starve_gnt_%0d", i), 32'(bus.dbg_gnt), 32'((i % 5) == 4));
      check_eq($sformatf("starve_stall_%0d", i), 32'(bus.core_stall), 32'((i % 5) == 4));
      if ((i % 5) == 4) sb_q.push_back(32'hDEAD_BEEF);
    end
    next_cycle();
    idle();

    // Collision on 0x010: only the core write lands, debug retries later
    next_cycle();
    drive(1'b1, 1'b1, 11'h010, 32'h1, 1'b1, 1'b1, 11'h010, 32'h2);
    check_eq("coll_gnt",   32'(bus.dbg_gnt),   32'd0);
    check_eq("coll_wdata", bus.ram_wdata,      32'h1);
    next_cycle();
    drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b1, 11'h010, 32'h2);
    check_eq("coll_ram_holds_core", bus.core_rdata, 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 11'h010, 32'h2);
    check_eq("coll_retry_gnt",   32'(bus.dbg_gnt), 32'd1);
    check_eq("coll_retry_wdata", bus.ram_wdata,    32'h2);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h010, '0);
    sb_q.push_back(32'h2);
    check_eq("coll_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
    next_cycle();
    idle();

    // Withdraw after 3 denials: counting restarts from zero
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 11'h020, '0, 1'b1, 1'b1, 11'h030, 32'h33);
      check_eq($sformatf("wd_pre_gnt_%0d", i), 32'(bus.dbg_gnt), 32'd0);
    end
    next_cycle();
    drive(1'b1, 1'b0, 11'h020, '0, 1'b0, 1'b1, 11'h030, 32'h33);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 11'h020, '0, 1'b1, 1'b1, 11'h030, 32'h33);
      check_eq($sformatf("wd_post_gnt_%0d", i), 32'(bus.dbg_gnt), 32'(i == 4));
    end
    next_cycle();
    idle();
    check_eq("wr_no_rvalid", 32'(bus.dbg_rvalid), 32'd0);

    // Back-to-back debug reads with the core halted
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h005, '0);
    sb_q.push_back(32'hDEAD_BEEF);
    check_eq("b2b_gnt_0", 32'(bus.dbg_gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h010, '0);
    sb_q.push_back(32'h2);
    check_eq("b2b_gnt_1", 32'(bus.dbg_gnt), 32'd1);
    check_eq("b2b_rvalid_1", 32'(bus.dbg_rvalid), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h030, '0);
    sb_q.push_back(32'h33);
    check_eq("b2b_gnt_2", 32'(bus.dbg_gnt), 32'd1);
    check_eq("b2b_rvalid_2", 32'(bus.dbg_rvalid), 32'd1);
    next_cycle();
    idle();
    check_eq("b2b_rvalid_3", 32'(bus.dbg_rvalid), 32'd1);

    // Reset right after a granted read cancels the pending rvalid
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h005, '0);
    check_eq("rst_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rst_rd_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    check_eq("rst_rd_gnt_off", 32'(bus.dbg_gnt), 32'd0);
    next_cycle();
    rst = 1'b1;
    idle();
    check_eq("rst_rd_rvalid_after", 32'(bus.dbg_rvalid), 32'd0);
    repeat (2) next_cycle();

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
